// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// digit-index type, digit positions, snapshot layout and segment patterns.
package seg_pkg;

  // Digit index, 0 = rightmost digit
  typedef logic [1:0] idx_t;

  localparam idx_t DIG_MSEC_L = 2'd0;
  localparam idx_t DIG_MSEC_H = 2'd1;
  localparam idx_t DIG_SEC_L  = 2'd2;
  localparam idx_t DIG_SEC_H  = 2'd3;

  // Segment code shown for anything that is not a decimal digit
  localparam logic [6:0] SEG_DASH = 7'h40;

  // seg[6:0] = g..a, active-high; entries 10..15 show a dash
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  // 15-bit per-frame copy of the stopwatch digits
  typedef struct packed {
    logic [2:0] sec_h;
    logic [3:0] sec_l;
    logic [3:0] msec_h;
    logic [3:0] msec_l;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit value to seven-segment pattern decoder.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; invalid BCD codes map to a dash inside the table
  assign seg = SEG_LUT[bcd];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit common-anode seven-segment driver fed by the
// stopwatch. Digits are captured once per frame and the display blinks
// while time_out is high.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN -- when defined, a zero
// seconds-tens digit is switched off instead of showing "0".
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] time_sec_h,
  input  logic [3:0] time_sec_l,
  input  logic [3:0] time_msec_h,
  input  logic [3:0] time_msec_l,
  input  logic       time_out,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] scan_cnt;
  idx_t          idx;
  snap_t         snap;
  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  logic          tick;
  logic          frame_end;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick      = (scan_cnt == CW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == DIG_SEC_H);

  // Dwell counter and digit index; idx wraps 3->0 at the frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= DIG_MSEC_L;
    end else if (tick) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Capture all digits together at the frame boundary to avoid tearing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
    end else if (frame_end) begin
      snap <= '{sec_h: time_sec_h, sec_l: time_sec_l,
                msec_h: time_msec_h, msec_l: time_msec_l};
    end
  end

  // Blink phase: frames counted only while time_out holds; dropping it relights at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!time_out) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Select the snapshot digit for the current scan position
  always_comb begin
    digit = '0;
    case (idx)
      DIG_MSEC_L: digit = snap.msec_l;
      DIG_MSEC_H: digit = snap.msec_h;
      DIG_SEC_L:  digit = snap.sec_l;
      DIG_SEC_H:  digit = {1'b0, snap.sec_h};
      default:    digit = '0;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Next output values: one enabled anode, decoded segments, dp after seconds
  always_comb begin
    an_next  = ~(4'b0001 << idx);
    seg_next = digit_seg;
    dp_next  = (idx == DIG_SEC_L);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if ((idx == DIG_SEC_H) && (snap.sec_h == 3'd0)) begin
      an_next  = 4'b1111;
      seg_next = 7'h00;
    end
`endif
    if (!blink_on) begin
      an_next  = 4'b1111;
      seg_next = 7'h00;
      dp_next  = 1'b0;
    end
  end

  // Registered pin drivers, all dark during reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'h00;
      dp  <= 1'b0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=2.
// A time-based reference model predicts an/seg/dp every cycle; directed
// literal checks pin the reference itself.
module tb_seg_scan_display;

  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] time_sec_h;
  logic [3:0] time_sec_l;
  logic [3:0] time_msec_h;
  logic [3:0] time_msec_l;
  logic       time_out;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .time_sec_h  (time_sec_h),
    .time_sec_l  (time_sec_l),
    .time_msec_h (time_msec_h),
    .time_msec_l (time_msec_l),
    .time_out    (time_out),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference: m_n edges since reset release; digit index follows from time
  int         m_n;
  int         m_d [4];
  bit         m_blink;
  int         m_fc;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  always begin
    @(posedge clk);
    if (!rst) begin
      m_n = 0; m_blink = 1'b1; m_fc = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
      e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
    end else begin
      int ix;
      int v;
      bit bnd;
      ix = (m_n / SD) % 4;
      v  = m_d[ix];
      if (!m_blink) begin
        e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
      end else begin
        e_an  = ~(4'b0001 << ix);
        e_seg = seg_of(v);
        e_dp  = (ix == 2);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (ix == 3 && v == 0) begin
          e_an = 4'hF; e_seg = 7'h00;
        end
`endif
      end
      m_n = m_n + 1;
      bnd = (m_n % (4 * SD)) == 0;
      if (bnd) begin
        m_d[0] = int'(time_msec_l); m_d[1] = int'(time_msec_h);
        m_d[2] = int'(time_sec_l);  m_d[3] = int'(time_sec_h);
      end
      if (!time_out) begin
        m_fc = 0; m_blink = 1'b1;
      end else if (bnd) begin
        m_fc = m_fc + 1;
        if (m_fc == BD) begin
          m_fc = 0; m_blink = !m_blink;
        end
      end
    end
    #1;
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
      errors++;
      $display("FAIL model t=%0t an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
               $time, an, seg, dp, e_an, e_seg, e_dp);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  // Advance negedges until an matches target; expiry counts as a failed check
  task automatic wait_an(input logic [3:0] target);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an === target) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_an timeout actual=%b required=%b", an, target);
  endtask

  task automatic set_digits(input int sh, input int sl, input int mh, input int ml);
    time_sec_h = 3'(sh); time_sec_l = 4'(sl); time_msec_h = 4'(mh); time_msec_l = 4'(ml);
  endtask

  initial begin
    int cnt;
    bit seen3;
    logic [6:0] seg3;
    rst = 1'b0; time_out = 1'b0;
    set_digits(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_an", {4'h0, an}, 8'h0F);
    check("reset_seg", {1'b0, seg}, 8'h00);
    rst = 1'b1;

    // Shows "00.00" immediately after release, digit 0 for SD cycles
    @(negedge clk);
    check("first_an", {4'h0, an}, 8'h0E);
    check("first_seg", {1'b0, seg}, 8'h3F);
    repeat (3) @(negedge clk);
    check("dwell_an", {4'h0, an}, 8'h0E);
    @(negedge clk);
    check("second_an", {4'h0, an}, 8'h0D);

    // Digit values 5,9,9,9
    set_digits(5, 9, 9, 9);
    repeat (17) @(negedge clk);
    wait_an(4'b0111);
    check("sech_seg", {1'b0, seg}, 8'h6D);
    check("sech_dp", {7'h0, dp}, 8'h00);
    wait_an(4'b1011);
    check("secl_seg", {1'b0, seg}, 8'h6F);
    check("secl_dp", {7'h0, dp}, 8'h01);

    // Snapshot: mid-frame change is held off until the boundary
    set_digits(1, 2, 3, 4);
    repeat (17) @(negedge clk);
    wait_an(4'b1110);
    check("snap_d0", {1'b0, seg}, 8'h66);
    set_digits(0, 0, 0, 0);
    wait_an(4'b1101);
    check("snap_d1", {1'b0, seg}, 8'h4F);
    wait_an(4'b1011);
    check("snap_d2", {1'b0, seg}, 8'h5B);
    wait_an(4'b0111);
    check("snap_d3", {1'b0, seg}, 8'h06);
    wait_an(4'b1110);
    check("snap_new", {1'b0, seg}, 8'h3F);

    // Invalid BCD shows a dash
    set_digits(5, 0, 0, 12);
    repeat (17) @(negedge clk);
    wait_an(4'b1110);
    check("dash_seg", {1'b0, seg}, 8'h40);

    // Blink: blank half-period is BD frames = 32 cycles
    time_out = 1'b1;
    wait_an(4'b1111);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an !== 4'b1111) break;
      cnt++;
    end
    check("blank_len", 8'(cnt), 8'd32);
    wait_an(4'b1111);
    repeat (3) @(negedge clk);
    time_out = 1'b0;
    repeat (2) @(negedge clk);
    check("relight", {7'h0, an === 4'b1111}, 8'h00);

    // Leading-zero handling of sec_h
    set_digits(0, 7, 7, 7);
    repeat (17) @(negedge clk);
    seen3 = 1'b0; seg3 = 7'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an[3] === 1'b0) begin
        seen3 = 1'b1; seg3 = seg;
      end
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_off", {7'h0, seen3}, 8'h00);
`else
    check("lz_on", {7'h0, seen3}, 8'h01);
    check("lz_seg", {1'b0, seg3}, 8'h3F);
`endif

    // Randomized traffic; the model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0)
        set_digits($urandom_range(0, 7), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) time_out = ~time_out;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        #1;
        check("async_rst_an", {4'h0, an}, 8'h0F);
        check("async_rst_seg", {1'b0, seg}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
